// File: rtl/mem_access_ctrl.sv
// Load/store controller between datapath and a word-wide data memory.
// Sub-word stores are done as read-modify-write since the memory only writes full words.
module mem_access_ctrl #(
    parameter int ADDR_W      = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writedata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [5:0]        mem_opcode,
    input  logic [31:0]       mem_readdata
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       merge_q, merge_d;
    logic              err_q, err_d;

    // Incoming request decode
    logic in_load, in_sw, in_sub, in_valid, in_misalign;
    always_comb begin
        in_load     = 1'b0;
        in_sw       = 1'b0;
        in_sub      = 1'b0;
        in_valid    = 1'b1;
        in_misalign = 1'b0;
        case (opcode)
            OP_LB, OP_LBU: in_load = 1'b1;
            OP_LH, OP_LHU: begin
                in_load     = 1'b1;
                in_misalign = addr[0];
            end
            OP_LW: begin
                in_load     = 1'b1;
                in_misalign = (addr[1:0] != 2'b00);
            end
            OP_SB: in_sub = 1'b1;
            OP_SH: begin
                in_sub      = 1'b1;
                in_misalign = addr[0];
            end
            OP_SW: begin
                in_sw       = 1'b1;
                in_misalign = (addr[1:0] != 2'b00);
            end
            default: in_valid = 1'b0;
        endcase
        if (!CHECK_ALIGN) in_misalign = 1'b0;
    end

    logic [ADDR_W-1:0] word_addr, load_addr;
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    // With alignment checks off, misaligned loads fall back to their natural boundary
    always_comb begin
        load_addr = addr_q;
        if (!CHECK_ALIGN) begin
            if (op_q == OP_LW)                          load_addr = word_addr;
            else if (op_q == OP_LH || op_q == OP_LHU)   load_addr = {addr_q[ADDR_W-1:1], 1'b0};
        end
    end

    logic [31:0] merged;
    always_comb begin
        merged = merge_q;
        if (op_q == OP_SB) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        merge_d = merge_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_d    = opcode;
                    addr_d  = addr;
                    wdata_d = wdata;
                    err_d   = !in_valid || in_misalign;
                    if (!in_valid || in_misalign) state_d = S_RESP;
                    else if (in_load)             state_d = S_LOAD;
                    else if (in_sw)               state_d = S_STORE;
                    else if (in_sub)              state_d = S_RMW_RD;
                    else                          state_d = S_RESP;
                end
            end
            S_LOAD: begin
                rdata_d = mem_readdata;
                state_d = S_RESP;
            end
            S_STORE:  state_d = S_RESP;
            S_RMW_RD: begin
                merge_d = mem_readdata;
                state_d = S_RMW_WR;
            end
            S_RMW_WR: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            merge_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
            err_q   <= err_d;
        end
    end

    // Memory strobes come only from registered state, so reset kills them at once
    always_comb begin
        mem_address   = '0;
        mem_writedata = '0;
        mem_write     = 1'b0;
        mem_read      = 1'b0;
        mem_opcode    = '0;
        case (state_q)
            S_LOAD: begin
                mem_read    = 1'b1;
                mem_opcode  = op_q;
                mem_address = load_addr;
            end
            S_STORE: begin
                mem_write     = 1'b1;
                mem_address   = word_addr;
                mem_writedata = wdata_q;
            end
            S_RMW_RD: begin
                mem_read    = 1'b1;
                mem_opcode  = OP_LW;
                mem_address = word_addr;
            end
            S_RMW_WR: begin
                mem_write     = 1'b1;
                mem_address   = word_addr;
                mem_writedata = merged;
            end
            default: ;
        endcase
    end

    assign ready = (state_q == S_IDLE);
    assign done  = (state_q == S_RESP);
    assign err   = (state_q == S_RESP) && err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a word-array reference model.
module tb_mem_access_ctrl;

    localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24,
                           LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2B;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic [5:0]  opcode = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready, done, err;
    logic [31:0] rdata;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_write, mem_read;
    logic [5:0]  mem_opcode;

    int vectors = 0;
    int errors  = 0;

    bit [31:0] mem     [64];
    bit [31:0] ref_mem [64];
    logic [31:0] ref_rdata = '0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .opcode(opcode), .addr(addr),
        .wdata(wdata), .ready(ready), .done(done), .err(err), .rdata(rdata),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_opcode(mem_opcode),
        .mem_readdata(mem_readdata)
    );

    // Data memory: full-word write on posedge, combinational opcode-aware read
    always @(posedge clk) if (mem_write) mem[mem_address[7:2]] <= mem_writedata;

    always_comb begin
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = mem[mem_address[7:2]];
        b = w[mem_address[1:0]*8 +: 8];
        h = mem_address[1] ? w[31:16] : w[15:0];
        case (mem_opcode)
            LB:      mem_readdata = {{24{b[7]}}, b};
            LBU:     mem_readdata = {24'h0, b};
            LH:      mem_readdata = {{16{h[15]}}, h};
            LHU:     mem_readdata = {16'h0, h};
            default: mem_readdata = w;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_bad(input logic [5:0] op, input logic [31:0] a);
        case (op)
            LB, LBU, SB: return 1'b0;
            LH, LHU, SH: return a[0];
            LW, SW:      return a[1:0] != 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

    // Reference semantics with shifts and masks over the word array
    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] a);
        logic [31:0] w, b, h;
        w = ref_mem[a[7:2]];
        b = (w >> (a[1:0] * 8)) & 32'hFF;
        h = (w >> (a[1] * 16)) & 32'hFFFF;
        case (op)
            LB:      return (b >= 32'h80) ? b + 32'hFFFFFF00 : b;
            LBU:     return b;
            LH:      return (h >= 32'h8000) ? h + 32'hFFFF0000 : h;
            LHU:     return h;
            default: return w;
        endcase
    endfunction

    task automatic ref_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] w, mask;
        int sh;
        w = ref_mem[a[7:2]];
        if (op == SW) begin
            ref_mem[a[7:2]] = wd;
        end else begin
            sh   = (op == SB) ? a[1:0] * 8 : a[1] * 16;
            mask = ((op == SB) ? 32'hFF : 32'hFFFF) << sh;
            ref_mem[a[7:2]] = (w & ~mask) | ((wd << sh) & mask);
        end
    endtask

    task automatic do_req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input bit hold);
        bit is_st, is_ld, bad, got_done;
        int exp_lat, exp_wr, exp_rd, cyc, wr, rd, w;
        bad    = ref_bad(op, a);
        is_st  = (op == SB || op == SH || op == SW);
        is_ld  = (op == LB || op == LH || op == LW || op == LBU || op == LHU);
        exp_lat = bad ? 1 : ((op == SB || op == SH) ? 3 : 2);
        exp_wr = (!bad && is_st) ? 1 : 0;
        exp_rd = (!bad && (is_ld || op == SB || op == SH)) ? 1 : 0;
        if (!bad && is_ld) ref_rdata = ref_load(op, a);
        if (!bad && is_st) ref_store(op, a, wd);

        @(negedge clk);
        w = 0;
        while (!ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_req", {31'b0, ready}, 32'd1);
        req = 1'b1; opcode = op; addr = a; wdata = wd;
        cyc = 0; wr = 0; rd = 0; got_done = 1'b0;
        while (cyc < 10 && !got_done) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && !hold) req = 1'b0;
            wr += int'(mem_write);
            rd |= int'(mem_read);
            if (done) begin
                got_done = 1'b1;
                req = 1'b0;
                check("err", {31'b0, err}, {31'b0, bad});
                check("rdata", rdata, ref_rdata);
            end
        end
        req = 1'b0;
        check("latency", cyc, exp_lat);
        check("write_pulses", wr, exp_wr);
        check("read_seen", rd, exp_rd);
        if (is_st) check("mem_word", mem[a[7:2]], ref_mem[a[7:2]]);
    endtask

    initial begin
        logic [5:0] valid_ops [8];
        logic [5:0] bad_ops [4];
        logic [5:0] op;
        logic [31:0] a;
        int r;
        valid_ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
        bad_ops   = '{6'h0F, 6'h22, 6'h2A, 6'h00};

        #1;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_write", {31'b0, mem_write}, 32'd0);
        check("rst_mem_read", {31'b0, mem_read}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Directed scenarios
        do_req(SW, 32'h10, 32'h11223344, 1'b0);
        do_req(SB, 32'h11, 32'h000000AA, 1'b0);
        check("sb_word", mem[4], 32'h1122AA44);
        do_req(SW, 32'h10, 32'h11223344, 1'b0);
        do_req(SH, 32'h12, 32'h0000BEEF, 1'b0);
        check("sh_word", mem[4], 32'hBEEF3344);
        do_req(LW, 32'h10, 32'h0, 1'b0);
        check("lw_value", rdata, 32'hBEEF3344);
        do_req(SW, 32'h20, 32'hDEADBEEF, 1'b0);
        do_req(LBU, 32'h23, 32'h0, 1'b0);
        check("lbu_value", rdata, 32'h000000DE);
        do_req(LB, 32'h23, 32'h0, 1'b0);
        check("lb_value", rdata, 32'hFFFFFFDE);
        do_req(LW, 32'h13, 32'h0, 1'b0);
        do_req(6'h0F, 32'h14, 32'h0, 1'b0);

        // req held high across a busy period: only one access
        do_req(SW, 32'h24, 32'hCAFEF00D, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("held_no_done", {31'b0, done}, 32'd0);
            check("held_no_write", {31'b0, mem_write}, 32'd0);
        end

        // Reset during the read phase of an SB
        do_req(SW, 32'h40, 32'h55667788, 1'b0);
        @(negedge clk);
        req = 1'b1; opcode = SB; addr = 32'h41; wdata = 32'h000000EE;
        @(negedge clk);
        req = 1'b0;
        check("abort_in_rmw_rd", {31'b0, mem_read}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_mem_write", {31'b0, mem_write}, 32'd0);
        check("abort_ready", {31'b0, ready}, 32'd1);
        check("abort_done", {31'b0, done}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_no_done", {31'b0, done}, 32'd0);
        end
        reset_n = 1'b1;
        ref_rdata = '0;
        check("abort_word", mem[16], 32'h55667788);
        check("abort_rdata", rdata, 32'd0);
        do_req(SW, 32'h30, 32'h0BADF00D, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 19);
            op = (r < 16) ? valid_ops[r % 8] : bad_ops[r - 16];
            a = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) begin
                if (op == LW || op == SW) a[1:0] = 2'b00;
                else if (op == LH || op == LHU || op == SH) a[0] = 1'b0;
            end
            do_req(op, a, $urandom, $urandom_range(0, 3) == 0);
        end

        for (int i = 0; i < 64; i++)
            if (mem[i] != ref_mem[i]) check("final_mem", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
